// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_hms core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

  localparam int unsigned SEC_W   = 6;
  localparam logic [5:0]  SEC_MAX = 6'd59;

  // Saturate a raw seconds preload to the legal 0..59 range.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Clock-to-second prescaler: counts enabled cycles, holds when disabled, and
// flags the last cycle of each second on tick_c.
module sw_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] cnt_q;

  assign tick_c = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_hms.sv
// Stopwatch/timer with prescaler, up/down counting, expiry and overflow.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_hms
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned MIN_W         = 7,
  parameter int unsigned MAX_MIN       = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             down,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] minutes,
  output logic             running,
  output logic             expired,
  output logic             overflow,
  output logic [5:0]       lap_sec,
  output logic [MIN_W-1:0] lap_min,
  output logic             lap_valid
);

  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);

  sw_state_e        state_q, state_nx;
  logic             down_q, down_nx;
  logic [5:0]       sec_nx, ld_sec;
  logic [MIN_W-1:0] min_nx, ld_min;
  logic             ovf_nx, exp_nx, run_nx;
  logic             tick_c, presc_en, presc_clr, last_down_c, start_idle_c;

  assign ld_sec       = clamp_sec(load_sec);
  assign ld_min       = (load_min > MIN_MAX) ? MIN_MAX : load_min;
  assign start_idle_c = (state_q == IDLE) && !load && start;
  assign last_down_c  = down_q && (seconds == 6'd1) && (minutes == '0);

  // Stop gates the prescaler so a stop edge never moves the count.
  assign presc_en  = (state_q == RUN) && !clear && !stop;
  assign presc_clr = clear || start_idle_c;

  sw_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (presc_en),
    .clr    (presc_clr),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_idle_c) state_nx = (down && seconds == '0 && minutes == '0) ? DONE : RUN;
        RUN:     if (stop) state_nx = PAUSE;
                 else if (tick_c && last_down_c) state_nx = DONE;
        PAUSE:   if (!stop && start) state_nx = RUN;
        DONE:    if (load) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next values for the registered outputs and the count arithmetic.
  always_comb begin
    sec_nx  = seconds;
    min_nx  = minutes;
    ovf_nx  = overflow;
    down_nx = down_q;
    run_nx  = (state_nx == RUN);
    exp_nx  = (state_nx == DONE) && (state_q != DONE);
    if (clear) begin
      sec_nx = '0;
      min_nx = '0;
      ovf_nx = 1'b0;
    end else if (load && (state_q == IDLE || state_q == DONE)) begin
      sec_nx = ld_sec;
      min_nx = ld_min;
    end else if (start_idle_c) begin
      down_nx = down;
    end else if (tick_c) begin
      if (down_q) begin
        if (seconds == '0) begin
          sec_nx = SEC_MAX;
          min_nx = minutes - MIN_W'(1);
        end else begin
          sec_nx = seconds - 6'd1;
        end
      end else if (seconds == SEC_MAX) begin
        sec_nx = '0;
        if (minutes == MIN_MAX) begin
          min_nx = '0;
          ovf_nx = 1'b1;
        end else begin
          min_nx = minutes + MIN_W'(1);
        end
      end else begin
        sec_nx = seconds + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds  <= '0;
      minutes  <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      overflow <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      seconds  <= sec_nx;
      minutes  <= min_nx;
      running  <= run_nx;
      expired  <= exp_nx;
      overflow <= ovf_nx;
      down_q   <= down_nx;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      lap_sec   <= seconds;
      lap_min   <= minutes;
      lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_sec    = '0;
  assign lap_min    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_hms.sv
// Bench for stopwatch_hms: TPS=1 and TPS=4 instances against a total-seconds model.
module tb_stopwatch_hms;

  localparam int MAXM = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct packed {
    int st; int total; int phase; bit dn; bit ovf; bit xp;
    int lsec; int lmin; bit lv;
  } m_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 0, stop = 0, clear = 0, lap = 0, down = 0, load = 0;
  logic [6:0] load_min = '0;
  logic [5:0] load_sec = '0;

  logic [5:0] s1, s4, ls1, ls4;
  logic [6:0] mi1, mi4, lm1, lm4;
  logic r1, r4, e1, e4, o1, o4, lv1, lv4;

  int n_vec = 0, n_err = 0;
  m_t m1, m4;

  always #5 clk = ~clk;

  stopwatch_hms #(.TICKS_PER_SEC(1), .MIN_W(7), .MAX_MIN(99)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .down(down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .seconds(s1), .minutes(mi1), .running(r1), .expired(e1), .overflow(o1),
    .lap_sec(ls1), .lap_min(lm1), .lap_valid(lv1));

  stopwatch_hms #(.TICKS_PER_SEC(4), .MIN_W(7), .MAX_MIN(99)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .down(down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .seconds(s4), .minutes(mi4), .running(r4), .expired(e4), .overflow(o4),
    .lap_sec(ls4), .lap_min(lm4), .lap_valid(lv4));

  function automatic int ldval(int lm, int ls);
    return ((ls > 59) ? 59 : ls) + 60 * ((lm > MAXM) ? MAXM : lm);
  endfunction

  // Value held as total seconds; one call per clock edge.
  function automatic m_t mstep(m_t m, int tps, bit st, bit sp, bit cl, bit ld, bit lp,
                               bit dn, int lm, int ls);
    m_t n = m;
    n.xp = 1'b0;
    if (cl) return '0;
`ifdef STOPWATCH_LAP_EN
    if (lp && (m.st == S_RUN || m.st == S_PAUSE)) begin
      n.lsec = m.total % 60; n.lmin = m.total / 60; n.lv = 1'b1;
    end
`else
    if (lp) n.lv = 1'b0;
`endif
    case (m.st)
      S_IDLE:
        if (ld) n.total = ldval(lm, ls);
        else if (st) begin
          n.dn = dn; n.phase = 0;
          if (dn && m.total == 0) begin n.st = S_DONE; n.xp = 1'b1; end
          else n.st = S_RUN;
        end
      S_RUN:
        if (sp) n.st = S_PAUSE;
        else begin
          n.phase = m.phase + 1;
          if (n.phase == tps) begin
            n.phase = 0;
            if (!m.dn) begin
              n.total = m.total + 1;
              if (n.total == (MAXM + 1) * 60) begin n.total = 0; n.ovf = 1'b1; end
            end else begin
              n.total = m.total - 1;
              if (n.total == 0) begin n.st = S_DONE; n.xp = 1'b1; end
            end
          end
        end
      S_PAUSE: if (!sp && st) n.st = S_RUN;
      default: if (ld) begin n.total = ldval(lm, ls); n.st = S_IDLE; end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0;
      m4 <= '0;
    end else begin
      m1 <= mstep(m1, 1, start, stop, clear, load, lap, down, int'(load_min), int'(load_sec));
      m4 <= mstep(m4, 4, start, stop, clear, load, lap, down, int'(load_min), int'(load_sec));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input logic [5:0] s, input logic [6:0] mi,
                     input logic r, input logic e, input logic o, input logic [5:0] lsx,
                     input logic [6:0] lmx, input logic lvx, input m_t m);
    chk({tag, ".seconds"},   int'(s),   m.total % 60);
    chk({tag, ".minutes"},   int'(mi),  m.total / 60);
    chk({tag, ".running"},   int'(r),   int'(m.st == S_RUN));
    chk({tag, ".expired"},   int'(e),   int'(m.xp));
    chk({tag, ".overflow"},  int'(o),   int'(m.ovf));
    chk({tag, ".lap_sec"},   int'(lsx), m.lsec);
    chk({tag, ".lap_min"},   int'(lmx), m.lmin);
    chk({tag, ".lap_valid"}, int'(lvx), int'(m.lv));
  endtask

  always @(negedge clk) begin
    cmp("tps1", s1, mi1, r1, e1, o1, ls1, lm1, lv1, m1);
    cmp("tps4", s4, mi4, r4, e4, o4, ls4, lm4, lv4, m4);
  end

  task automatic drive(input bit st, input bit sp, input bit cl, input bit ld, input bit lp,
                       input bit dn, input int lm, input int ls);
    start = st; stop = sp; clear = cl; load = ld; lap = lp; down = dn;
    load_min = 7'(lm); load_sec = 6'(ls);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic val1(input string name, input int mm, input int ss);
    chk({name, ".min"}, int'(mi1), mm);
    chk({name, ".sec"}, int'(s1), ss);
  endtask

  initial begin
    bit a_st, a_sp, a_cl, a_ld, a_lp, a_dn;
    int a_lm, a_ls;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.running", int'(r1), 0);
    chk("reset.seconds", int'(s1), 0);
    rst_n = 1'b1;
    idle(1);

    // 1: run 130 s, pause, resume, async reset
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1.running", int'(r1), 1);
    idle(130);
    val1("t1.run130", 2, 10);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(20);
    val1("t1.paused", 2, 10);
    chk("t1.paused_running", int'(r1), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    val1("t1.resume_edge", 2, 10);
    idle(1);
    val1("t1.resumed", 2, 11);
    #3 rst_n = 1'b0;
    #1;
    chk("t1.async_sec1", int'(s1), 0);
    chk("t1.async_min1", int'(mi1), 0);
    chk("t1.async_run1", int'(r1), 0);
    chk("t1.async_sec4", int'(s4), 0);
    chk("t1.async_run4", int'(r4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // 2: overflow wrap from 99:58
    drive(0, 0, 0, 1, 0, 0, 99, 58);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    val1("t2.max", 99, 59);
    idle(1);
    val1("t2.wrap", 0, 0);
    chk("t2.overflow", int'(o1), 1);
    chk("t2.running", int'(r1), 1);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("t2.ovf_cleared", int'(o1), 0);
    chk("t2.idle", int'(r1), 0);

    // 3: count down to expiry
    drive(0, 0, 0, 1, 0, 0, 0, 3);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    val1("t3.start", 0, 3);
    idle(2);
    val1("t3.one", 0, 1);
    idle(1);
    val1("t3.zero", 0, 0);
    chk("t3.expired", int'(e1), 1);
    chk("t3.stopped", int'(r1), 0);
    idle(1);
    chk("t3.expired_once", int'(e1), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    val1("t3.done_hold", 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 5);
    val1("t3.reload", 0, 5);
    drive(0, 0, 1, 0, 0, 0, 0, 0);

    // 4: start+stop together, load in PAUSE
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    val1("t4.frozen", 0, 3);
    chk("t4.paused", int'(r1), 0);
    idle(2);
    drive(0, 0, 0, 1, 0, 0, 10, 10);
    val1("t4.load_ignored", 0, 3);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    val1("t4.clear", 0, 0);

    // 5: TPS=4 partial second survives a pause
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("t5.before", int'(s4), 0);
    idle(1);
    chk("t5.first", int'(s4), 1);
    idle(2);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(10);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("t5.resume1", int'(s4), 1);
    idle(1);
    chk("t5.resume2", int'(s4), 2);
    drive(0, 0, 1, 0, 0, 0, 0, 0);

    // 6: lap at 1:05
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(65);
    val1("t6.pre", 1, 5);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    val1("t6.continues", 1, 6);
`ifdef STOPWATCH_LAP_EN
    chk("t6.lap_min", int'(lm1), 1);
    chk("t6.lap_sec", int'(ls1), 5);
    chk("t6.lap_valid", int'(lv1), 1);
`else
    chk("t6.lap_valid", int'(lv1), 0);
`endif
    drive(0, 0, 1, 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      a_cl = ($urandom_range(0, 99) < 2);
      a_ld = ($urandom_range(0, 99) < 6);
      a_st = !a_ld && ($urandom_range(0, 99) < 8);
      a_sp = !a_ld && ($urandom_range(0, 99) < 5);
      a_lp = ($urandom_range(0, 99) < 5);
      a_dn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a_lm = int'($urandom_range(0, 1));
        1:       a_lm = int'($urandom_range(98, 127));
        default: a_lm = int'($urandom_range(0, 127));
      endcase
      a_ls = int'($urandom_range(0, 63));
      drive(a_st, a_sp, a_cl, a_ld, a_lp, a_dn, a_lm, a_ls);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_hms.md
# stopwatch_hms

Parametrised stopwatch/timer core, the successor to the fixed seconds/minutes stopwatch. It keeps start/stop/resume semantics and adds:
- a clock-to-second prescaler
- configurable minute range
- count-down mode with a preloadable value, an expiry pulse and sticky overflow
- optional lap capture

It sits directly under the display/control top level and is driven by debounced single-cycle pulses.

## Interface
Parameters:
- TICKS_PER_SEC, default 1: clock cycles per counted second (≥1).
- MIN_W, default 7: minutes counter width.
- MAX_MIN, default 99: highest minute value (≤ 2^MIN_W−1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  start/resume pulse.
- stop  in  1  pause pulse.
- clear  in  1  synchronous clear to IDLE.
- lap  in  1  lap-capture pulse.
- down  in  1  mode select, latched on start from IDLE (1 = count down).
- load  in  1  preload strobe.
- load_min  in  MIN_W  preload minutes.
- load_sec  in  6  preload seconds.
- seconds  out  6  current seconds, 0..59.
- minutes  out  MIN_W  current minutes, 0..MAX_MIN.
- running  out  1  high while in RUN.
- expired  out  1  one-cycle pulse when a count-down reaches 0:00.
- overflow  out  1  sticky flag: up-count wrapped past MAX_MIN:59.
- lap_sec  out  6  captured seconds.
- lap_min  out  MIN_W  captured minutes.
- lap_valid  out  1  lap registers hold a capture.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE. Reset → IDLE; every output is 0, prescaler is 0, mode register is up.
- Input priority, per cycle: clear > load > stop > start.
  - clear in any state → IDLE; zeroes counters, prescaler, overflow and lap registers.
- IDLE:
  - load → counters take load_sec clamped to 59 and load_min clamped to MAX_MIN.
  - start → RUN. Latches `down`; zeroes the prescaler.
  - start with down=1 and value 0:00 → DONE, with an expired pulse.
- RUN:
  - stop → PAUSE.
  - start is ignored.
  - load is ignored.
- PAUSE:
  - start → RUN. The prescaler is held, not reset, so the partial second is retained.
  - load is ignored.
- DONE: counters hold at 0:00. start and stop are ignored. load → IDLE, with the value loaded.
- tick = (state==RUN) && (prescaler==TICKS_PER_SEC−1). The prescaler wraps to 0 on tick.
- Up mode, on tick:
  - seconds 59 → 0, and minutes increments.
  - At MAX_MIN:59 → 0:00, overflow set (sticky until clear/reset), stays in RUN.
- Down mode, on tick:
  - seconds 0 → 59, and minutes decrements.
  - At 0:01 → 0:00, state → DONE, expired high for exactly the following cycle.
- Simultaneous start+stop in RUN or PAUSE: stop wins, result is PAUSE.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- start sampled at edge N → running=1 after edge N.
  - With TICKS_PER_SEC=1, the first increment is visible after edge N+1.
  - In general, the first increment is visible after edge N+TICKS_PER_SEC.
- stop sampled at edge N → no counter change at edge N or later.
- expired is asserted in the cycle after the edge on which the count became 0:00.
- The lap capture is visible one edge after lap is sampled.
- Asynchronous rst_n assertion mid-count clears all state immediately, without waiting for clk.

## Configuration
- STOPWATCH_LAP_EN defined:
  - lap in RUN or PAUSE copies seconds/minutes into lap_sec/lap_min and sets lap_valid; counting continues uninterrupted.
  - A later lap overwrites the capture.
  - lap in IDLE or DONE is ignored.
- STOPWATCH_LAP_EN undefined:
  - The lap input is ignored.
  - lap_sec, lap_min and lap_valid are tied to 0.
  - No lap registers are synthesised.
  - The ports remain present.

## Structure
- Package stopwatch_pkg: state enum (IDLE, RUN, PAUSE, DONE) and constant SEC_MAX=59.
- Sub-module sw_prescaler: TICKS_PER_SEC counter with enable and hold, and a clear input; produces tick.
- The FSM and the seconds/minutes up/down arithmetic live in stopwatch_hms.

## Test plan
1. Reset, then start; run 130 cycles (TPS=1) → 2:10. Then:
   - stop; wait 20 cycles → value stays 2:10.
   - start → 2:11 one edge later.
   - Assert rst_n=0 mid-run → all outputs 0 immediately.
2. Load 99:58 in up mode, then start → 99:59, then 0:00; overflow=1, running=1. Then clear → overflow=0, state IDLE.
3. Load 0:03, down=1, then start → 0:02, 0:01, 0:00, then:
   - expired pulses for one cycle; running=0.
   - A further start keeps the value 0:00.
   - load 0:05 → IDLE with value 0:05.
4. In RUN, pulse start and stop together → PAUSE, value frozen. Then clear → 0:00, IDLE; a load during PAUSE has no effect.
5. TICKS_PER_SEC=4: seconds advances every 4 cycles. Pause after 2 cycles into a second, hold 10 cycles, resume → the next increment arrives exactly 2 cycles later.
6. Lap pulse at 1:05 with STOPWATCH_LAP_EN defined → lap_min=1, lap_sec=5, lap_valid=1, and the count continues to 1:06. Without the macro → lap_valid stays 0.
